// File: rtl/card_dealer.sv
// card_dealer: deals card codes 1..13 sampled from a free-running rank counter, handed off via valid/ready.
// Define SHOE_TRACK_EN for a finite shoe without replacement; otherwise cards are dealt with replacement.
module card_dealer #(
    parameter int NUM_DECKS = 1,
    parameter int CNT_W = 4,
    parameter int LEFT_W = 6
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              deal_req,
    input  logic              shuffle,
    input  logic              card_ready,
    output logic              card_valid,
    output logic [3:0]        card,
    output logic              shoe_empty,
    output logic [LEFT_W-1:0] cards_left
);
    localparam logic [LEFT_W-1:0] FULL_LEFT = LEFT_W'(52 * NUM_DECKS);
    typedef enum logic [1:0] {IDLE, SEARCH, PRESENT} state_t;
    state_t state, state_n;
    logic [3:0] rank;
    logic accept;
    assign card_valid = state == PRESENT;
    assign accept = card_valid && card_ready;
    always_ff @(posedge clk)
        if (!resetb) rank <= 4'd1;
        else rank <= (rank == 4'd13) ? 4'd1 : rank + 4'd1;
`ifdef SHOE_TRACK_EN
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(4 * NUM_DECKS);
    logic [CNT_W-1:0] cnt [1:13];
    logic [3:0] cand, cand_n;
    logic hit, found, refill;
    assign shoe_empty = cards_left == '0;
    assign cand_n = (cand == 4'd13) ? 4'd1 : cand + 4'd1;
    assign hit = cnt[rank] != '0;
    assign found = cnt[cand_n] != '0;
    assign refill = state == IDLE && shuffle;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (!shuffle && deal_req && !shoe_empty) state_n = hit ? PRESENT : SEARCH;
            SEARCH:  if (found) state_n = PRESENT;
            default: if (card_ready) state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state <= IDLE;
            card <= '0;
            cand <= 4'd1;
            cards_left <= FULL_LEFT;
            cnt <= '{default: FULL_CNT};
        end else begin
            state <= state_n;
            // the candidate tracks the rank while idle so SEARCH starts from the sampled rank
            if (state == IDLE) cand <= rank;
            else if (state == SEARCH) cand <= cand_n;
            if (state == IDLE && state_n == PRESENT) card <= rank;
            else if (state == SEARCH && state_n == PRESENT) card <= cand_n;
            if (refill) begin
                cnt <= '{default: FULL_CNT};
                cards_left <= FULL_LEFT;
            end else if (accept) begin
                cnt[card] <= cnt[card] - CNT_W'(1);
                cards_left <= cards_left - LEFT_W'(1);
            end
        end
    end
`else
    logic unused;
    assign unused = shuffle | (CNT_W == 0);
    assign shoe_empty = 1'b0;
    assign cards_left = FULL_LEFT;
    always_comb begin
        state_n = state;
        if (state == IDLE && deal_req) state_n = PRESENT;
        else if (accept) state_n = IDLE;
    end
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state <= IDLE;
            card <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && deal_req) card <= rank;
        end
    end
`endif
endmodule
